down_timer: RTL and testbench

//  Programmable down-counting timer; the counterpart of the free-running up counter.

---
 rtl/timer_pkg.sv | 12 +
 rtl/tick_prescaler.sv | 28 ++
 rtl/down_timer.sv | 109 ++++++++++
 tb/tb_down_timer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared timer definitions.
// State encoding is reused by later timer and watchdog blocks.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } timer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: one tick every (prescale+1) enabled cycles.
// The >= compare recovers cleanly if prescale shrinks mid-count.
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = en && (cnt >= prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Programmable down-counting timer with one-shot/periodic
// reload, pause and resume.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  periodic,
  input  logic                  start,
  input  logic                  stop,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expired
);

  timer_state_t     state;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] c_eff;
  logic             tick;
  logic             pre_en;
  logic             pre_clr;
  logic             go;

  // HOLD keeps the prescaler so a resume continues mid-period.
  assign pre_en  = (state == RUN) && !stop;
  assign pre_clr = (state == IDLE) || (state == DONE);
  assign go      = start && !stop;

  always_comb begin
    c_eff = load ? load_val : count;
  end

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_pre (
    .clk      (clk),
    .reset    (reset),
    .en       (pre_en),
    .clr      (pre_clr),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      busy    <= 1'b0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      unique case (state)
        IDLE, HOLD: begin
          if (load) begin
            count  <= load_val;
            reload <= load_val;
          end
          if (go && (c_eff != '0)) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        DONE: begin
          if (load) begin
            count  <= load_val;
            reload <= load_val;
            if (go && (load_val != '0)) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (go && (reload != '0)) begin
            count <= reload;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= HOLD;
            busy  <= 1'b0;
          end else if (tick) begin
            if (count == 1) begin
              expired <= 1'b1;
              if (periodic && (reload != '0)) begin
                count <= reload;
              end else begin
                count <= '0;
                state <= DONE;
                busy  <= 1'b0;
              end
            end else if (count > 1) begin
              count <= count - 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer.
// Expected values come from closed-form tick arithmetic.
module tb_down_timer;

  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [W-1:0]  load_val;
  logic [PW-1:0] prescale;
  logic          periodic;
  logic          start;
  logic          stop;
  logic [W-1:0]  count;
  logic          busy;
  logic          expired;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  down_timer #(
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .prescale (prescale),
    .periodic (periodic),
    .start    (start),
    .stop     (stop),
    .count    (count),
    .busy     (busy),
    .expired  (expired)
  );

  // Model: k edges after the start edge, t = k/(p+1) ticks elapsed.
  function automatic int m_count(int c, int p, bit per, int k);
    int t;
    t = k / (p + 1);
    if (per) return c - (t % c);
    return (t < c) ? c - t : 0;
  endfunction

  function automatic bit m_exp(int c, int p, bit per, int k);
    int t;
    t = k / (p + 1);
    if (k == 0 || (k % (p + 1)) != 0) return 1'b0;
    return per ? ((t % c) == 0) : (t == c);
  endfunction

  function automatic bit m_busy(int c, int p, bit per, int k);
    if (per) return 1'b1;
    return (k / (p + 1)) < c;
  endfunction

  task automatic step(input logic ld, input int lv,
                      input logic st, input logic sp);
    load     = ld;
    load_val = W'(lv);
    start    = st;
    stop     = sp;
    @(posedge clk);
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int d;
    do_reset();
    total++;
    if (count !== 0 || busy !== 0 || expired !== 0)
      $display("FAIL reset_init count=%0d busy=%0b exp=%0b req 0/0/0",
               count, busy, expired);
    else passed++;
    prescale = 0;
    periodic = 1'b0;
    step(1, 9, 1, 0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    d = $urandom_range(1, 3);
    #(d);
    reset = 1'b1;
    #1;
    total++;
    if (count !== 0 || busy !== 0 || expired !== 0)
      $display("FAIL reset_async count=%0d busy=%0b exp=%0b req 0/0/0",
               count, busy, expired);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (count !== 0 || busy !== 0 || expired !== 0)
      $display("FAIL reset_held count=%0d busy=%0b exp=%0b req 0/0/0",
               count, busy, expired);
    else passed++;
  endtask

  task automatic test_oneshot();
    do_reset();
    prescale = 0;
    periodic = 1'b0;
    step(1, 5, 1, 0);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (count !== W'(m_count(5, 0, 0, k)) ||
          expired !== m_exp(5, 0, 0, k) ||
          busy !== m_busy(5, 0, 0, k))
        $display("FAIL oneshot k=%0d got %0d/%0b/%0b req %0d/%0b/%0b",
                 k, count, expired, busy, m_count(5, 0, 0, k),
                 m_exp(5, 0, 0, k), m_busy(5, 0, 0, k));
      else passed++;
    end
  endtask

  task automatic test_periodic();
    int npulse;
    do_reset();
    prescale = 2;
    periodic = 1'b1;
    npulse   = 0;
    step(1, 3, 1, 0);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      if (expired === 1'b1) npulse++;
      total++;
      if (count !== W'(m_count(3, 2, 1, k)) ||
          expired !== m_exp(3, 2, 1, k) || busy !== 1'b1)
        $display("FAIL periodic k=%0d got %0d/%0b/%0b req %0d/%0b/1",
                 k, count, expired, busy, m_count(3, 2, 1, k),
                 m_exp(3, 2, 1, k));
      else passed++;
    end
    total++;
    if (npulse != 4)
      $display("FAIL periodic_pulses got %0d req 4", npulse);
    else passed++;
  endtask

  task automatic test_pause();
    int hit;
    do_reset();
    prescale = 1;
    periodic = 1'b0;
    step(1, 6, 1, 0);
    repeat (4) @(negedge clk);
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (count !== 4 || busy !== 0 || expired !== 0)
        $display("FAIL hold i=%0d got %0d/%0b/%0b req 4/0/0",
                 i, count, busy, expired);
      else passed++;
    end
    // 4 run edges used before stop; 12 total, so 8 after resume
    step(0, 0, 1, 0);
    hit = 0;
    for (int k = 1; k <= 10 && hit == 0; k++) begin
      @(negedge clk);
      if (expired === 1'b1) hit = k;
    end
    total++;
    if (hit != 8)
      $display("FAIL resume_expiry edge=%0d req 8", hit);
    else passed++;
    total++;
    if (count !== 0 || busy !== 0)
      $display("FAIL resume_done got %0d/%0b req 0/0", count, busy);
    else passed++;
  endtask

  task automatic test_corners();
    do_reset();
    prescale = 0;
    periodic = 1'b0;
    step(0, 0, 1, 0);
    total++;
    if (busy !== 0 || count !== 0)
      $display("FAIL start_zero got %0d/%0b req 0/0", count, busy);
    else passed++;
    step(1, 7, 1, 0);
    step(1, 2, 0, 0);
    total++;
    if (count !== 6 || busy !== 1)
      $display("FAIL load_in_run got %0d/%0b req 6/1", count, busy);
    else passed++;
    step(0, 0, 1, 1);
    @(negedge clk);
    total++;
    if (count !== 6 || busy !== 0)
      $display("FAIL stop_wins got %0d/%0b req 6/0", count, busy);
    else passed++;
  endtask

  task automatic test_done_restart();
    do_reset();
    prescale = 0;
    periodic = 1'b0;
    step(1, 4, 1, 0);
    repeat (5) @(negedge clk);
    step(0, 0, 1, 0);
    total++;
    if (count !== 4 || busy !== 1)
      $display("FAIL done_restart got %0d/%0b req 4/1", count, busy);
    else passed++;
    repeat (5) @(negedge clk);
    step(1, 2, 1, 0);
    total++;
    if (count !== 2 || busy !== 1)
      $display("FAIL done_load_start got %0d/%0b req 2/1", count, busy);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (expired !== 1 || count !== 0)
      $display("FAIL done_reexpire got %0b/%0d req 1/0", expired, count);
    else passed++;
  endtask

  task automatic test_random();
    int c, p, n;
    bit per;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      c   = $urandom_range(1, 15);
      p   = $urandom_range(0, 3);
      per = 1'($urandom_range(0, 1));
      n   = $urandom_range(10, 60);
      prescale = PW'(p);
      periodic = per;
      step(1, c, 1, 0);
      for (int k = 0; k <= n; k++) begin
        if (k > 0) @(negedge clk);
        total++;
        if (count !== W'(m_count(c, p, per, k)) ||
            expired !== m_exp(c, p, per, k) ||
            busy !== m_busy(c, p, per, k))
          $display("FAIL rand c=%0d p=%0d per=%0b k=%0d got %0d/%0b/%0b req %0d/%0b/%0b",
                   c, p, per, k, count, expired, busy,
                   m_count(c, p, per, k), m_exp(c, p, per, k),
                   m_busy(c, p, per, k));
        else passed++;
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    load_val = '0;
    prescale = '0;
    periodic = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_corners();
    test_done_restart();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
